// File: rtl/adau_audio_stream_pkg.sv
// Shared definitions for the audio stream buffer: register map, STATUS/CTRL
// bit positions and drain FSM encoding.
package audio_stream_pkg;

    localparam logic [1:0] REG_DATA_L = 2'd0;
    localparam logic [1:0] REG_DATA_R = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERRUN  = 3;
    localparam int ST_LEVEL_LSB = 8;
    localparam int ST_UCNT_LSB  = 16;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_WM_LSB = 8;
    localparam int CTRL_WM_W   = 8;
    localparam int CTRL_FLUSH  = 30;
    localparam int CTRL_CLEAR  = 31;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_ISSUE = 2'd1,
        DRAIN_WAIT  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/adau_audio_stream_if.sv
// Wishbone classic slave window (4 words) as seen by the audio stream buffer.
interface adau_audio_stream_if;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;

    modport slave (
        input  i_wb_addr, i_wb_data, i_wb_sel, i_wb_stb, i_wb_we,
        output o_wb_data, o_wb_ack, o_wb_stall
    );

    modport master (
        output i_wb_addr, i_wb_data, i_wb_sel, i_wb_stb, i_wb_we,
        input  o_wb_data, o_wb_ack, o_wb_stall
    );
endinterface

// File: rtl/adau_audio_stream_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head is presented through a
// registered RAM read so the storage maps onto block RAM.
module sync_fifo #(
    parameter int WIDTH      = 48,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  push_dropped
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      head_reg;
    logic [DEPTH_LOG2:0]   wr_ptr_reg;
    logic [DEPTH_LOG2:0]   rd_ptr_reg;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // Pop is resolved first so a full FIFO that pops can still accept a push.
    assign pop_ok       = pop && !empty && !flush;
    assign push_ok      = push && !flush && (!full || pop_ok);
    assign push_dropped = push && !flush && !push_ok;
    assign head_data    = head_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    // Head is re-read every cycle; a frame pushed at least one cycle earlier is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg <= '0;
        end else begin
            head_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adau_audio_stream.sv
// Wishbone-fed stereo sample buffer draining one frame per request into i2s_master,
// with fill level, overflow and underrun status for polling firmware.
module adau_audio_stream
    import audio_stream_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int SAMPLE_W   = 24,
    parameter int UNDERRUN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    adau_audio_stream_if.slave   wb,
    output logic [SAMPLE_W-1:0]  frame_l,
    output logic [SAMPLE_W-1:0]  frame_r,
    output logic                 write_frame,
    input  logic                 i2s_full,
    output logic                 irq_low
);

    drain_state_t              state_reg, state_next;
    logic [SAMPLE_W-1:0]       staged_l_reg;
    logic                      enable_reg;
    logic [CTRL_WM_W-1:0]      low_wm_reg;
    logic                      overflow_reg;
    logic                      underrun_reg;
    logic                      udr_cond_prev_reg;
    logic [UNDERRUN_W-1:0]     udr_cnt_reg;
    logic                      ack_reg;
    logic [31:0]               rdata_reg;
    logic [31:0]               rdata_next;
    logic [31:0]               status_word;
    logic [31:0]               ctrl_word;

    logic                      wr_stb, rd_stb;
    logic                      fifo_push, fifo_pop, flush, clear, issue;
    logic                      udr_cond, udr_inc;
    logic [2*SAMPLE_W-1:0]     fifo_head;
    logic [DEPTH_LOG2:0]       fifo_level;
    logic                      fifo_full, fifo_empty, fifo_dropped;
    logic [1:0][SAMPLE_W-1:0]  chan_out;
    logic                      unused_bits;

    assign wr_stb    = wb.i_wb_stb && wb.i_wb_we;
    assign rd_stb    = wb.i_wb_stb && !wb.i_wb_we;
    assign fifo_push = wr_stb && (wb.i_wb_addr == REG_DATA_R);
    assign flush     = wr_stb && (wb.i_wb_addr == REG_CTRL) && wb.i_wb_data[CTRL_FLUSH];
    assign clear     = wr_stb && (wb.i_wb_addr == REG_CTRL) && wb.i_wb_data[CTRL_CLEAR];
    assign unused_bits = ^{wb.i_wb_sel, wb.i_wb_data[29:SAMPLE_W]};

    sync_fifo #(
        .WIDTH      (2*SAMPLE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (fifo_push),
        .push_data    ({staged_l_reg, wb.i_wb_data[SAMPLE_W-1:0]}),
        .pop          (fifo_pop),
        .flush        (flush),
        .head_data    (fifo_head),
        .level        (fifo_level),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .push_dropped (fifo_dropped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DRAIN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A flush aborts an issue: no strobe, no pop, straight back to idle.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            DRAIN_IDLE: begin
                if (enable_reg && !fifo_empty && !i2s_full && !flush) begin
                    state_next = DRAIN_ISSUE;
                end
            end
            DRAIN_ISSUE: begin
                if (flush) begin
                    state_next = DRAIN_IDLE;
                end else begin
                    issue      = 1'b1;
                    fifo_pop   = 1'b1;
                    state_next = DRAIN_WAIT;
                end
            end
            DRAIN_WAIT: state_next = DRAIN_IDLE;
            default:    state_next = DRAIN_IDLE;
        endcase
    end

    assign write_frame = issue;

    // Channel 0 is left (upper half of the stored frame), channel 1 is right.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [SAMPLE_W-1:0] hold_reg;
        logic [SAMPLE_W-1:0] head_sample;

        assign head_sample = fifo_head[(1-gi)*SAMPLE_W +: SAMPLE_W];

        always_ff @(posedge clk) begin
            if (reset) begin
                hold_reg <= '0;
            end else if (issue) begin
                hold_reg <= head_sample;
            end
        end

        assign chan_out[gi] = issue ? head_sample : hold_reg;
    end

    assign frame_l = chan_out[0];
    assign frame_r = chan_out[1];

    assign udr_cond = (state_reg == DRAIN_IDLE) && enable_reg && fifo_empty && !i2s_full;
    assign udr_inc  = udr_cond && !udr_cond_prev_reg;

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            staged_l_reg      <= '0;
            enable_reg        <= 1'b0;
            low_wm_reg        <= '0;
            overflow_reg      <= 1'b0;
            underrun_reg      <= 1'b0;
            udr_cond_prev_reg <= 1'b0;
            udr_cnt_reg       <= '0;
        end else begin
            if (wr_stb && (wb.i_wb_addr == REG_DATA_L)) begin
                staged_l_reg <= wb.i_wb_data[SAMPLE_W-1:0];
            end
            if (wr_stb && (wb.i_wb_addr == REG_CTRL)) begin
                enable_reg <= wb.i_wb_data[CTRL_EN];
                low_wm_reg <= wb.i_wb_data[CTRL_WM_LSB +: CTRL_WM_W];
            end
            if (fifo_dropped) begin
                overflow_reg <= 1'b1;
            end else if (clear) begin
                overflow_reg <= 1'b0;
            end
            if (udr_cond) begin
                underrun_reg <= 1'b1;
            end else if (clear) begin
                underrun_reg <= 1'b0;
            end
            if (clear) begin
                udr_cnt_reg <= udr_inc ? UNDERRUN_W'(1) : '0;
            end else if (udr_inc && (udr_cnt_reg != '1)) begin
                udr_cnt_reg <= udr_cnt_reg + 1'b1;
            end
            udr_cond_prev_reg <= udr_cond;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[ST_EMPTY]    = fifo_empty;
        status_word[ST_FULL]     = fifo_full;
        status_word[ST_OVERFLOW] = overflow_reg;
        status_word[ST_UNDERRUN] = underrun_reg;
        status_word[ST_LEVEL_LSB +: DEPTH_LOG2+1] = fifo_level;
        status_word[ST_UCNT_LSB +: UNDERRUN_W]    = udr_cnt_reg;

        ctrl_word = '0;
        ctrl_word[CTRL_EN] = enable_reg;
        ctrl_word[CTRL_WM_LSB +: CTRL_WM_W] = low_wm_reg;

        case (wb.i_wb_addr)
            REG_DATA_L: rdata_next = 32'(staged_l_reg);
            REG_STATUS: rdata_next = status_word;
            REG_CTRL:   rdata_next = ctrl_word;
            default:    rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg   <= wb.i_wb_stb;
            rdata_reg <= rd_stb ? rdata_next : '0;
        end
    end

    assign wb.o_wb_ack   = ack_reg;
    assign wb.o_wb_data  = rdata_reg;
    assign wb.o_wb_stall = 1'b0;
    assign irq_low       = enable_reg && (32'(fifo_level) <= 32'(low_wm_reg));

endmodule
